aes_round_engine: RTL and testbench



---
 rtl/aes_pkg.sv | 19 +
 rtl/mixcolumn.sv | 25 ++
 rtl/subbytes.sv | 35 +++
 rtl/aes_round_engine.sv | 112 +++++++++++
 tb/tb_aes_round_engine.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, GF(2^8) helper and the round-engine FSM encoding.
package aes_pkg;

  localparam int          AES_BLOCK_W = 128;
  localparam int          AES_NR_128  = 10;
  localparam logic [7:0]  GF_POLY     = 8'h1B;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  // Multiply by x in GF(2^8), reducing by x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mixcolumn.sv
// MixColumns for a single column; byte 0 (row 0) is in bits [31:24].
module mixcolumn
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;

  always_comb begin
    a0 = col_i[31:24];
    a1 = col_i[23:16];
    a2 = col_i[15:8];
    a3 = col_i[7:0];
    // 3*a is expressed as xtime(a) ^ a.
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    col_o = {b0, b1, b2, b3};
  end

endmodule

// File: rtl/subbytes.sv
// SubBytes: sixteen parallel AES S-boxes, purely combinational.
module subbytes (
  input  logic [127:0] sb_in,
  output logic [127:0] sb_out
);

  // Entry for input byte b sits at bits [2047-8b -: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    assign sb_out[8*i +: 8] = sbox(sb_in[8*i +: 8]);
  end

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES encryption datapath: one full round per clock, valid/ready on both sides.
//   state | meaning
//   IDLE  | ready for a plaintext block; whitening key rk[0] applied on accept
//   ROUND | one round per cycle, rk_idx = round counter; last round skips MixColumns
//   DONE  | ciphertext presented and held until out_ready
module aes_round_engine
  import aes_pkg::*;
#(
  parameter int NR     = AES_NR_128,
  parameter int KIDX_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_block,
  output logic [KIDX_W-1:0]      rk_idx,
  input  logic [AES_BLOCK_W-1:0] rk,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_block
);

  localparam logic [KIDX_W-1:0] NR_K = KIDX_W'(NR);

  aes_state_e               fsm_q, fsm_d;
  logic [AES_BLOCK_W-1:0]   state_q, state_d;
  logic [KIDX_W-1:0]        rnd_q, rnd_d;
  logic                     out_valid_q, out_valid_d;

  logic [AES_BLOCK_W-1:0]   sb_out, sr_out, mc_out, round_out;
  logic                     last_round;

  subbytes u_subbytes (
    .sb_in  (state_q),
    .sb_out (sb_out)
  );

  // ShiftRows: byte i = r + 4c lives at bits [127-8i -: 8].
  always_comb begin
    sr_out = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sr_out[127-8*(r+4*c) -: 8] = sb_out[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    mixcolumn u_mixcolumn (
      .col_i (sr_out[127-32*c -: 32]),
      .col_o (mc_out[127-32*c -: 32])
    );
  end

  assign last_round = (rnd_q == NR_K);
  assign round_out  = (last_round ? sr_out : mc_out) ^ rk;

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    rnd_d       = rnd_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;
    rk_idx      = '0;
    unique case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = in_block ^ rk;
          rnd_d   = KIDX_W'(1);
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        rk_idx  = rnd_q;
        state_d = round_out;
        if (last_round) begin
          fsm_d       = DONE;
          out_valid_d = 1'b1;
        end else begin
          rnd_d = rnd_q + KIDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d       = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      rnd_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_block = state_q;

endmodule

// File: tb/tb_aes_round_engine.sv
// Directed bench for aes_round_engine using FIPS-197 vectors and an independent key schedule.
module tb_aes_round_engine;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;

  logic [127:0] ks [0:15];
  int           cyc = 0;
  int           ntests = 0;
  int           nfail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rk = ks[rk_idx];

  aes_round_engine #(.NR(10), .KIDX_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .rk_idx    (rk_idx),
    .rk        (rk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block)
  );

  function automatic logic [7:0] tb_xtime(input logic [7:0] b);
    return b[7] ? ((b << 1) ^ 8'h1b) : (b << 1);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = tb_xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    return (x << k) | (x >> (8 - k));
  endfunction

  // S-box derived from the field inverse and affine map rather than a table.
  function automatic logic [7:0] sbox_f(input logic [7:0] b);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (b != 8'h00 && gmul(b, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_f(t[31:24]), sbox_f(t[23:16]), sbox_f(t[15:8]), sbox_f(t[7:0])};
        t = t ^ {rcon, 24'h000000};
        rcon = tb_xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk({tag, "_ready_timeout"}, 128'(in_ready), 128'd1);
  endtask

  task automatic wait_out(input string tag, output int seen);
    int n = 0;
    seen = -1;
    while (seen < 0 && n < 60) begin
      @(negedge clk);
      if (out_valid) seen = cyc;
      n++;
    end
    if (seen < 0) chk({tag, "_out_timeout"}, 128'(out_valid), 128'd1);
  endtask

  task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] ct);
    int acc;
    int seen;
    wait_ready(tag);
    in_valid = 1'b1;
    in_block = pt;
    acc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(tag, seen);
    chk({tag, "_latency"}, 128'(seen - acc), 128'd11);
    chk({tag, "_ct"}, out_block, ct);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int acc;
    int seen;
    int prev;
    logic [127:0] held;

    for (int i = 0; i < 16; i++) ks[i] = '0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_block = '0;
    out_ready = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_block", out_block, 128'd0);
    chk("rst_rk_idx", 128'(rk_idx), 128'd0);
    rst = 1'b0;
    @(negedge clk);

    load_key(KEY_C);
    run_block("appc", PT_C, CT_C);

    // App B with the round-key index sequence observed cycle by cycle.
    load_key(KEY_B);
    wait_ready("appb");
    in_valid = 1'b1;
    in_block = PT_B;
    acc = cyc;
    chk("appb_rk_idx0", 128'(rk_idx), 128'd0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("appb_rk_idx%0d", k), 128'(rk_idx), 128'(k));
    end
    wait_out("appb", seen);
    chk("appb_latency", 128'(seen - acc), 128'd11);
    chk("appb_ct", out_block, CT_B);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Backpressure: sink stalls for 20 cycles, then a new block follows.
    run_block("bp_pre", PT_B, CT_B);
    wait_ready("bp");
    in_valid = 1'b1;
    in_block = PT_B;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out("bp", seen);
    held = out_block;
    chk("bp_ct", held, CT_B);
    for (int i = 0; i < 20; i++) begin
      chk("bp_stable", out_block, held);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      @(negedge clk);
    end
    load_key(KEY_C);
    in_valid = 1'b1;
    in_block = PT_C;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_rel_out_valid", 128'(out_valid), 128'd0);
    chk("bp_rel_in_ready", 128'(in_ready), 128'd1);
    acc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_accepted", 128'(in_ready), 128'd0);
    wait_out("bp_next", seen);
    chk("bp_next_latency", 128'(seen - acc), 128'd11);
    chk("bp_next_ct", out_block, CT_C);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Back-to-back with in_valid and out_ready held high.
    out_ready = 1'b1;
    prev = -1;
    for (int n = 0; n < 3; n++) begin
      wait_ready("b2b");
      load_key(n == 1 ? KEY_C : KEY_B);
      in_block = (n == 1) ? PT_C : PT_B;
      in_valid = 1'b1;
      wait_out("b2b", seen);
      if (n == 2) in_valid = 1'b0;
      chk($sformatf("b2b_ct%0d", n), out_block, (n == 1) ? CT_C : CT_B);
      if (prev >= 0) chk($sformatf("b2b_gap%0d", n), 128'(seen - prev), 128'd12);
      prev = seen;
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_no_extra", 128'(in_ready), 128'd1);

    // Inputs toggled during ROUND must not disturb the block in flight.
    load_key(KEY_B);
    wait_ready("ign");
    in_valid = 1'b1;
    in_block = PT_B;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_block = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_out("ign", seen);
    chk("ign_ct", out_block, CT_B);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset while round 5 is in progress.
    wait_ready("rst_mid");
    in_valid = 1'b1;
    in_block = PT_C;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && rk_idx != 4'd5; i++) @(negedge clk);
    chk("rst_mid_reached5", 128'(rk_idx), 128'd5);
    rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", 128'(in_ready), 128'd1);
    chk("rst_mid_out_valid", 128'(out_valid), 128'd0);
    chk("rst_mid_out_block", out_block, 128'd0);
    chk("rst_mid_rk_idx", 128'(rk_idx), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_no_output", 128'(out_valid), 128'd0);
    run_block("rst_mid_appb", PT_B, CT_B);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
